// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the burst master.
//   HTRANS_*   transfer type codes
//   HBURST_*   burst type codes
//   HRESP_*    response codes
//   state_e    master FSM states
//   beats_of() beat count of a burst code (INCR of undefined length counts as one beat)
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StLast,
    StErr2
  } state_e;

  function automatic logic [4:0] beats_of(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address for an AHB burst.
//   addr      current beat address
//   hsize     transfer size, step = 1 << hsize
//   hburst    burst type; WRAPx bursts wrap inside a beats*step window
//   next_addr address of the following beat
module ahb_addr_gen import ahb_pkg::*; #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;
  logic              wrap;

  always_comb begin
    step = ADDR_W'(1) << hsize;
    incr = addr + step;
    // Low bits that roll over inside the wrap window; upper bits are held.
    mask = (ADDR_W'(beats_of(hburst)) << hsize) - ADDR_W'(1);
    wrap = (hburst == HBURST_WRAP4) || (hburst == HBURST_WRAP8) || (hburst == HBURST_WRAP16);
    if (wrap) begin
      next_addr = (addr & ~mask) | (incr & mask);
    end else begin
      next_addr = incr;
    end
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one command (address, direction, size, burst) becomes a pipelined
// NONSEQ/SEQ/BUSY sequence, with write data streamed in and read data streamed out.
//   hclk, hreset                  clock, synchronous active-high reset
//   cmd_*                         command handshake and fields
//   wdata_valid/wdata_ready/wdata write beat stream (one-entry holding register)
//   rdata_valid/rdata             read beat pulses, straight from hrdata
//   done/err                      end-of-burst pulse, err set when ended by ERROR
//   haddr..hwdata, hready, hresp, hrdata  AHB-Lite master port
// Bus control is registered; done/err/rdata_valid are decoded from state and the slave response.
// The caller keeps cmd_size within the data bus width and bursts inside a 1 KB page.
module ahb_burst_master import ahb_pkg::*; #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [1:0]        hresp,
  input  logic [DATA_W-1:0] hrdata
);

  state_e            state_q;
  logic [1:0]        htrans_q;
  logic [ADDR_W-1:0] naddr_q;   // address of the next beat to issue
  logic [4:0]        rem_q;     // beats not yet issued
  logic              first_q;   // no beat issued yet in this burst
  logic              dph_q;     // a data phase is outstanding
  logic [DATA_W-1:0] hold_q;

  logic              accept;
  logic              bus_err;
  logic              can_issue;
  logic              wr_sel;
  logic [2:0]        cmd_burst_n;
  logic [ADDR_W-1:0] gen_addr;
  logic [2:0]        gen_size;
  logic [2:0]        gen_burst;
  logic [ADDR_W-1:0] gen_next;

  ahb_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .addr     (gen_addr),
    .hsize    (gen_size),
    .hburst   (gen_burst),
    .next_addr(gen_next)
  );

  always_comb begin
    accept      = cmd_valid & cmd_ready;
    bus_err     = dph_q & ~hready & (hresp != HRESP_OKAY);
    // Undefined-length INCR runs as a single beat, so it is issued as SINGLE.
    cmd_burst_n = (cmd_burst == HBURST_INCR) ? HBURST_SINGLE : cmd_burst;
    // In IDLE the command is still on the inputs; afterwards it lives in the bus registers.
    wr_sel      = (state_q == StIdle) ? cmd_write   : hwrite;
    gen_addr    = (state_q == StIdle) ? cmd_addr    : naddr_q;
    gen_size    = (state_q == StIdle) ? cmd_size    : hsize;
    gen_burst   = (state_q == StIdle) ? cmd_burst_n : hburst;
    can_issue   = 1'b0;
    unique case (state_q)
      StIdle:  can_issue = accept & hready & (~cmd_write | wdata_valid);
      StAddr:  can_issue = hready & (rem_q != 5'd0) & (~hwrite | wdata_valid);
      default: can_issue = 1'b0;
    endcase
    wdata_ready = can_issue & wr_sel;
    // First ERROR cycle cancels the pending address phase without waiting for the clock.
    htrans      = bus_err ? HTRANS_IDLE : htrans_q;
    rdata_valid = dph_q & ~hwrite & hready & (hresp == HRESP_OKAY);
    rdata       = hrdata;
    done        = hready & ((state_q == StLast) | (state_q == StErr2));
    err         = hready & (state_q == StErr2);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= StIdle;
      htrans_q  <= HTRANS_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hsize     <= 3'd0;
      hburst    <= 3'd0;
      hwdata    <= '0;
      hold_q    <= '0;
      naddr_q   <= '0;
      rem_q     <= 5'd0;
      first_q   <= 1'b0;
      dph_q     <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      if (hready) begin
        dph_q <= htrans_q[1];
        if (htrans_q[1]) begin
          hwdata <= hold_q;
        end
      end
      if (wdata_ready) begin
        hold_q <= wdata;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StAddr;
            cmd_ready <= 1'b0;
            hwrite    <= cmd_write;
            hsize     <= cmd_size;
            hburst    <= cmd_burst_n;
            if (can_issue) begin
              haddr    <= cmd_addr;
              htrans_q <= HTRANS_NONSEQ;
              naddr_q  <= gen_next;
              rem_q    <= beats_of(cmd_burst_n) - 5'd1;
              first_q  <= 1'b0;
            end else begin
              naddr_q  <= cmd_addr;
              rem_q    <= beats_of(cmd_burst_n);
              first_q  <= 1'b1;
            end
          end
        end
        StAddr: begin
          if (bus_err) begin
            htrans_q <= HTRANS_IDLE;
            state_q  <= StErr2;
          end else if (hready) begin
            if (can_issue) begin
              haddr    <= naddr_q;
              htrans_q <= first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
              naddr_q  <= gen_next;
              rem_q    <= rem_q - 5'd1;
              first_q  <= 1'b0;
            end else if (rem_q == 5'd0) begin
              htrans_q <= HTRANS_IDLE;
              state_q  <= StLast;
            end else if (!first_q) begin
              // Write data stalled mid-burst: BUSY announces the next beat's address.
              haddr    <= naddr_q;
              htrans_q <= HTRANS_BUSY;
            end
          end
        end
        StLast: begin
          if (bus_err) begin
            state_q <= StErr2;
          end else if (hready) begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
          end
        end
        StErr2: begin
          if (hready) begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
module tb_ahb_burst_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [2:0]        cmd_burst;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  ahb_burst_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .done       (done),
    .err        (err),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hwdata     (hwdata),
    .hready     (hready),
    .hresp      (hresp),
    .hrdata     (hrdata)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  // Slave model state: data phase bookkeeping and captured write beats.
  logic        dph_wr   = 1'b0;
  logic        dph_rd   = 1'b0;
  logic [31:0] dph_addr = 32'd0;
  logic [31:0] wq[$];

  logic [31:0] wrap4_addr [4] = '{32'h0C, 32'h00, 32'h04, 32'h08};
  logic [1:0]  busy_trans [6] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
  logic [31:0] busy_addr  [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC};
  logic        busy_vld   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] busy_wd    [6] = '{32'hA2, 32'h0, 32'h0, 32'hA3, 32'hA4, 32'h0};

  int n;
  logic seen_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq_chk(input string tag, input int k, input logic [31:0] exp);
    logic [31:0] v;
    v = (wq.size() > k) ? wq[k] : 32'bx;
    chk(tag, v, exp);
  endtask

  // One clock: record the completing data phase, cross the edge, return read data for it.
  task automatic tick();
    if (hready) begin
      if (dph_wr && hresp == 2'b00) wq.push_back(hwdata);
      dph_wr   = htrans[1] & hwrite;
      dph_rd   = htrans[1] & ~hwrite;
      dph_addr = haddr;
    end
    @(posedge hclk);
    #1;
    if (dph_rd) hrdata = dph_addr + 32'd1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = 3'd0;
    cmd_burst = 3'd0; wdata_valid = 1'b0; wdata = '0; hready = 1'b1; hresp = 2'b00;
    hrdata = '0;
    tick();
    tick();
    hreset = 1'b0;
    #1;
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_hsize", hsize, 0);
    chk("rst_hburst", hburst, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // WRAP4 write at 0x0C, data 1..4.
    wq.delete();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_size = 3'd2;
    cmd_burst = 3'b010; wdata_valid = 1'b1; wdata = 32'd1;
    #1;
    chk("wrap4_wready", wdata_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdata = 32'(i + 2);
      #1;
      chk("wrap4_htrans", htrans, (i == 0) ? 2'b10 : 2'b11);
      chk("wrap4_haddr", haddr, wrap4_addr[i]);
      if (i > 0) chk("wrap4_hwdata", hwdata, 32'(i));
      chk("wrap4_done_early", done, 0);
      tick();
    end
    wdata_valid = 1'b0;
    #1;
    chk("wrap4_idle", htrans, 2'b00);
    chk("wrap4_hwdata4", hwdata, 32'd4);
    chk("wrap4_done", done, 1);
    chk("wrap4_err", err, 0);
    tick();
    #1;
    chk("wrap4_done_clr", done, 0);
    chk("wrap4_cmd_ready", cmd_ready, 1);
    chk("wrap4_wq_size", wq.size(), 4);
    for (int k = 0; k < 4; k++) wq_chk("wrap4_wq", k, 32'(k + 1));

    // INCR8 read at 0x100; slave returns address + 1.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_size = 3'd2;
    cmd_burst = 3'b101;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("incr8_hburst", hburst, 3'b101);
    chk("incr8_hwrite", hwrite, 0);
    n = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      #1;
      if (rdata_valid) begin
        chk("incr8_rdata", rdata, 32'h101 + 32'(4 * n));
        n++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("incr8_err", err, 0);
      end else begin
        tick();
      end
    end
    chk("incr8_beats", n, 8);
    chk("incr8_done", seen_done, 1);
    tick();

    // INCR4 write with write data stalled two cycles before beat 3.
    wq.delete();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_size = 3'd2;
    cmd_burst = 3'b011; wdata_valid = 1'b1; wdata = 32'hA1;
    #1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wdata_valid = busy_vld[i];
      wdata = busy_wd[i];
      #1;
      chk("busy_htrans", htrans, busy_trans[i]);
      chk("busy_haddr", haddr, busy_addr[i]);
      tick();
    end
    #1;
    chk("busy_idle", htrans, 2'b00);
    chk("busy_done", done, 1);
    tick();
    chk("busy_wq_size", wq.size(), 4);
    for (int k = 0; k < 4; k++) wq_chk("busy_wq", k, 32'hA1 + 32'(k));

    // INCR4 read at 0x200 with hready low for three cycles.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_size = 3'd2;
    cmd_burst = 3'b011;
    #1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    seen_done = 1'b0;
    for (int c = 1; c <= 12 && !seen_done; c++) begin
      hready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      #1;
      if (rdata_valid) begin
        chk("stall_rdata", rdata, 32'h201 + 32'(4 * n));
        n++;
      end
      if (!hready) begin
        chk("stall_haddr", haddr, 32'h208);
        chk("stall_htrans", htrans, 2'b11);
        chk("stall_rvalid", rdata_valid, 0);
      end
      if (done) seen_done = 1'b1;
      else tick();
    end
    hready = 1'b1;
    chk("stall_beats", n, 4);
    chk("stall_done", seen_done, 1);
    tick();

    // ERROR on beat 2 of an INCR8 write.
    wq.delete();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_size = 3'd2;
    cmd_burst = 3'b101; wdata_valid = 1'b1; wdata = 32'hB0;
    #1;
    tick();
    cmd_valid = 1'b0;
    wdata = 32'hB1;
    #1;
    chk("errb_nonseq", htrans, 2'b10);
    tick();
    wdata = 32'hB2;
    #1;
    chk("errb_seq", htrans, 2'b11);
    chk("errb_haddr", haddr, 32'h304);
    tick();
    hresp = 2'b01; hready = 1'b0;
    #1;
    chk("errb_cancel", htrans, 2'b00);
    chk("errb_done_early", done, 0);
    chk("errb_wready", wdata_ready, 0);
    tick();
    hready = 1'b1;
    #1;
    chk("errb_done", done, 1);
    chk("errb_err", err, 1);
    chk("errb_idle", htrans, 2'b00);
    tick();
    hresp = 2'b00;
    #1;
    chk("errb_cmd_ready", cmd_ready, 1);
    chk("errb_no_beat", htrans, 2'b00);
    chk("errb_done_clr", done, 0);
    tick();
    #1;
    chk("errb_still_idle", htrans, 2'b00);
    chk("errb_wq_size", wq.size(), 1);
    wq_chk("errb_wq", 0, 32'hB0);
    wdata_valid = 1'b0;

    // Reset during beat 3 of an INCR16 read, then a SINGLE write.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h400; cmd_size = 3'd2;
    cmd_burst = 3'b111;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("rst16_nonseq", htrans, 2'b10);
    tick();
    tick();
    #1;
    chk("rst16_beat3", haddr, 32'h408);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    #1;
    chk("rst16_htrans", htrans, 2'b00);
    chk("rst16_cmd_ready", cmd_ready, 1);
    chk("rst16_haddr", haddr, 0);
    chk("rst16_done", done, 0);
    tick();
    #1;
    chk("rst16_done2", done, 0);
    chk("rst16_idle2", htrans, 2'b00);

    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_size = 3'd2;
    cmd_burst = 3'b000; wdata_valid = 1'b1; wdata = 32'hABCD;
    #1;
    tick();
    cmd_valid = 1'b0; wdata_valid = 1'b0;
    #1;
    chk("single_htrans", htrans, 2'b10);
    chk("single_haddr", haddr, 32'h40);
    chk("single_hburst", hburst, 3'b000);
    chk("single_hwrite", hwrite, 1);
    tick();
    #1;
    chk("single_idle", htrans, 2'b00);
    chk("single_hwdata", hwdata, 32'hABCD);
    chk("single_done", done, 1);
    chk("single_err", err, 0);
    tick();
    #1;
    chk("single_cmd_ready", cmd_ready, 1);
    chk("single_done_clr", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- AHB-Lite master that sits directly upstream of the AHB SRAM controller and drives its hclk-domain slave port.
- Turns one command (start address, direction, size, burst type) into a legal pipelined AHB transfer sequence: NONSEQ/SEQ/BUSY/IDLE on htrans, address increment and wrap, hwdata one cycle behind address.
- Streams write data in and read data out over valid/ready side-bands. Used by system benches and DMA-style traffic sources.

Parameters:
- ADDR_W, 32, haddr and cmd_addr width
- DATA_W, 32, hwdata/hrdata width; hsize is legal only up to log2(DATA_W/8)

Ports:
- hclk  in  1  clock, all logic on rising edge
- hreset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address; must be aligned to cmd_size
- cmd_size  in  3  AHB hsize encoding
- cmd_burst  in  3  AHB hburst: 000 SINGLE, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16; 001 (INCR undefined length) is treated as SINGLE
- wdata_valid  in  1  write beat available
- wdata_ready  out  1  write beat consumed
- wdata  in  DATA_W  write beat
- rdata_valid  out  1  one-cycle pulse per completed read beat
- rdata  out  DATA_W  read beat
- done  out  1  one-cycle pulse when the burst completes, normally or on error
- err  out  1  valid with done; 1 = burst ended by ERROR response
- haddr  out  ADDR_W  AHB address
- htrans  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  out  1  AHB direction
- hsize  out  3  AHB size
- hburst  out  3  AHB burst
- hwdata  out  DATA_W  AHB write data, data phase
- hready  in  1  slave ready
- hresp  in  2  00 OKAY, 01 ERROR; other codes are treated as ERROR
- hrdata  in  DATA_W  slave read data

Behaviour:
- Reset values: htrans = IDLE; haddr, hwrite, hsize, hburst, hwdata = 0; cmd_ready = 1; wdata_ready, rdata_valid, done, err = 0. Reset mid-burst aborts immediately. No done pulse is produced for the aborted burst.
- Beat count: SINGLE = 1, x4 = 4, x8 = 8, x16 = 16. Step = 1 << hsize.
- INCR: next address = addr + step. A 1 KB boundary crossing is the caller's responsibility and is not checked.
- WRAP: the low log2(beats*step) address bits increment modulo; the upper bits are held.
- States:
  - IDLE: cmd_ready = 1. On accept, latch the command and go to ADDR.
  - ADDR: address phases are issued.
  - LAST: the final data phase is outstanding.
  - ERR2: second cycle of an ERROR response.
- Address phase:
  - The first beat drives NONSEQ and later beats drive SEQ.
  - An address phase advances only when hready = 1. haddr, htrans, hsize, hburst and hwrite stay stable while hready = 0.
- Write bursts:
  - A beat's address phase is issued only when wdata_valid = 1. wdata_ready pulses in that cycle and the beat is latched into a 1-entry holding register.
  - The holding register drives hwdata in the next (data) cycle and is held while hready = 0.
  - If wdata_valid = 0 for a non-first beat, drive BUSY at the current address. This is not legal before the first beat: stay IDLE on htrans instead.
- Read bursts: rdata_valid = 1 and rdata = hrdata in every cycle where a read data phase completes with hready = 1 and hresp = OKAY.
- Pipelining: address of beat n+1 overlaps data of beat n. Back-to-back beats with hready = 1 give one beat per cycle. Latency from cmd accept to first NONSEQ on the bus is 1 cycle.
- Completion:
  - After the final beat's address phase, drive IDLE and go to LAST.
  - When the final data phase completes, done = 1 and err = 0. Go to IDLE and set cmd_ready = 1 in the following cycle.
  - A new command may then issue NONSEQ on the cycle after accept. No back-to-back command overlap.
- ERROR (hresp != OKAY with hready = 0):
  - In that first cycle, drive htrans = IDLE (cancel the pending beat) and go to ERR2.
  - In ERR2 (hready = 1): done = 1, err = 1, return to IDLE.
  - The errored beat gives no rdata_valid.
  - Write data already latched is discarded. The source must flush its remaining beats.
- Simultaneous cmd_valid and done: the command is not accepted until IDLE.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HBURST_* codes
  - HRESP_OKAY/ERROR
  - state enum IDLE/ADDR/LAST/ERR2
  - a function beats_of(hburst)
- One sub-module, ahb_addr_gen, is combinational: next address from (addr, hsize, hburst) with increment and wrap.

Test Plan:
- WRAP4 write, addr 0x0C, size 2, data 1..4, wdata always valid, hready = 1 → haddr 0x0C, 0x00, 0x04, 0x08; htrans 10, 11, 11, 11 then 00; hwdata lags haddr by 1 cycle; done after 5 cycles.
- INCR8 read, addr 0x100, size 2, slave returns addr+1 → 8 rdata_valid pulses with data 0x101 to 0x11D step 4; done, err = 0.
- INCR4 write with wdata_valid low for beat 3 for 2 cycles → htrans 10, 11, 01, 01, 11, 11; haddr held at 0x008 during BUSY; all 4 beats written in order.
- hready low for 3 cycles mid-INCR4 read → address/control and the data phase held stable; no duplicate or dropped rdata_valid.
- ERROR on beat 2 of INCR8 write (hresp = 01, hready = 0 then 1) → htrans = IDLE in the first error cycle; done = 1 with err = 1; no further beats issued.
- Assert hreset during beat 3 of INCR16 → next cycle htrans = 0 and cmd_ready = 1; no done; a following SINGLE write completes normally.
